// File: rtl/fpu_cmp_minmax_stage_pkg.sv
// Shared definitions for the FP compare/min/max result stage: op codes, flag bits, recoded width, canonical NaN.
// Pure declarations; no logic or timing of its own.
package fpu_cmp_minmax_stage_pkg;

    localparam int REC_W  = 33;
    localparam int FLAG_W = 5;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [REC_W-1:0] CANON_NAN = 33'h0_E040_0000;

    typedef enum logic [2:0] {
        FPU_CMP_FEQ  = 3'd0,
        FPU_CMP_FLT  = 3'd1,
        FPU_CMP_FLE  = 3'd2,
        FPU_CMP_FMIN = 3'd3,
        FPU_CMP_FMAX = 3'd4
    } fpu_cmp_op_e;

    // Everything S1 captures at accept time, comparator results included.
    typedef struct packed {
        logic [2:0]        op;
        logic [REC_W-1:0]  a;
        logic [REC_W-1:0]  b;
        logic              lt;
        logic              eq;
        logic [FLAG_W-1:0] exc;
    } s1_t;

    function automatic logic is_nan(input logic [REC_W-1:0] x);
        return x[31:29] == 3'b111;
    endfunction

    function automatic logic is_snan(input logic [REC_W-1:0] x);
        return is_nan(x) && !x[22];
    endfunction

endpackage

// File: rtl/fpu_minmax_sel.sv
// NaN classification and result mux for compare/min/max ops on recoded operands.
// Purely combinational, zero latency; no handshake.
module fpu_minmax_sel
    import fpu_cmp_minmax_stage_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [REC_W-1:0] a,
    input  logic [REC_W-1:0] b,
    input  logic             lt,
    input  logic             eq,
    output logic [REC_W-1:0] result
);

    logic a_nan;
    logic b_nan;
    logic pick_a_min;
    logic pick_a_max;

    assign a_nan = is_nan(a);
    assign b_nan = is_nan(b);

    // On equality the sign bit breaks the tie so -0 orders below +0.
    assign pick_a_min = lt || (eq && a[32]);
    assign pick_a_max = (!lt && !eq) || (eq && !a[32]);

    always_comb begin
        result = {{(REC_W-1){1'b0}}, eq};
        case (op)
            FPU_CMP_FLT: result = {{(REC_W-1){1'b0}}, lt};
            FPU_CMP_FLE: result = {{(REC_W-1){1'b0}}, lt | eq};
            FPU_CMP_FMIN, FPU_CMP_FMAX: begin
                if (a_nan && b_nan)
                    result = CANON_NAN;
                else if (a_nan)
                    result = b;
                else if (b_nan)
                    result = a;
                else if (op == FPU_CMP_FMIN)
                    result = pick_a_min ? a : b;
                else
                    result = pick_a_max ? a : b;
            end
            default: result = {{(REC_W-1){1'b0}}, eq};
        endcase
    end

endmodule

// File: rtl/fpu_cmp_minmax_stage.sv
// Two-stage registered FEQ/FLT/FLE/FMIN/FMAX result path around the recoded comparator; optional sticky fflags (FPU_CMP_FFLAGS_ACC_EN).
// Latency 2 cycles accept-to-out_valid, full throughput with out_ready high.
// Backpressure: S2 holds stable while out_ready is low; in_ready depends combinationally on out_ready.
module fpu_cmp_minmax_stage
    import fpu_cmp_minmax_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REC_W-1:0]  in_a,
    input  logic [REC_W-1:0]  in_b,
    output logic              cmp_signaling,
    input  logic              cmp_lt,
    input  logic              cmp_eq,
    input  logic [FLAG_W-1:0] cmp_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REC_W-1:0]  out_data,
    output logic [FLAG_W-1:0] out_exc,
    output logic [FLAG_W-1:0] fflags,
    input  logic              fflags_clr
);

    s1_t               s1_d;
    s1_t               s1_q;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_load;
    logic              fire;
    logic [REC_W-1:0]  s1_result;
    logic [REC_W-1:0]  s2_data;
    logic [FLAG_W-1:0] s2_exc;

    assign cmp_signaling = (in_op == FPU_CMP_FLT) || (in_op == FPU_CMP_FLE);

    assign s2_load  = !s2_valid || out_ready;
    // During flush the pipe empties next edge, so upstream may be offered ready; the op is simply not captured.
    assign in_ready = !s1_valid || s2_load || flush;
    assign fire     = in_valid && in_ready && !flush;

    assign s1_d = '{op: in_op, a: in_a, b: in_b, lt: cmp_lt, eq: cmp_eq, exc: cmp_exc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (in_ready)
                s1_valid <= in_valid;
            if (fire)
                s1_q <= s1_d;
        end
    end

    fpu_minmax_sel u_sel (
        .op     (s1_q.op),
        .a      (s1_q.a),
        .b      (s1_q.b),
        .lt     (s1_q.lt),
        .eq     (s1_q.eq),
        .result (s1_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_exc   <= '0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_load)
                s2_valid <= s1_valid;
            if (s2_load && s1_valid && !flush) begin
                s2_data <= s1_result;
                s2_exc  <= s1_q.exc;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_exc   = s2_exc;

`ifdef FPU_CMP_FFLAGS_ACC_EN
    logic [FLAG_W-1:0] acc_in;
    logic [FLAG_W-1:0] fflags_q;

    assign acc_in = (out_valid && out_ready && !flush) ? out_exc : '0;

    // Clear wins over history but not over the op accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fflags_q <= '0;
        else if (fflags_clr)
            fflags_q <= acc_in;
        else
            fflags_q <= fflags_q | acc_in;
    end

    assign fflags = fflags_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags = '0;
`endif

endmodule

// File: tb/tb_fpu_cmp_minmax_stage.sv
// Bench for fpu_cmp_minmax_stage: vector table streamed through a scoreboard, plus stall, flush and reset sequences.
module tb_fpu_cmp_minmax_stage;
    import fpu_cmp_minmax_stage_pkg::*;

`ifdef FPU_CMP_FFLAGS_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif
    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [32:0] in_a = '0;
    logic [32:0] in_b = '0;
    logic        cmp_signaling;
    logic        cmp_lt = 1'b0;
    logic        cmp_eq = 1'b0;
    logic [4:0]  cmp_exc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [32:0] out_data;
    logic [4:0]  out_exc;
    logic [4:0]  fflags;
    logic        fflags_clr = 1'b0;

    fpu_cmp_minmax_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .cmp_signaling(cmp_signaling),
        .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_exc(cmp_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [32:0] a;
        logic [32:0] b;
        logic        lt;
        logic        eq;
        logic [4:0]  exc;
        logic [32:0] exp_data;
        logic [4:0]  exp_exc;
    } vec_t;

    typedef struct {
        logic [32:0] data;
        logic [4:0]  exc;
        int          cyc;
    } sb_t;

    vec_t        vecs[NV];
    sb_t         sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_accept = 0;
    bit          chk_lat = 1'b0;
    logic [4:0]  ff_model = '0;
    logic [32:0] cur_data = '0;
    logic [4:0]  cur_exc = '0;
    bit          prev_stall = 1'b0;
    logic [32:0] prev_data = '0;
    logic [4:0]  prev_exc = '0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard, hold-stability and fflags model, all sampled mid-cycle.
    always @(negedge clk) begin
        sb_t        e;
        logic [4:0] acc;
        acc = '0;
        if (!rst_n) begin
            sbq.delete();
            ff_model   = '0;
            prev_stall = 1'b0;
        end else begin
            check("fflags", {28'b0, fflags}, {28'b0, ACC_EN ? ff_model : 5'd0});
            if (in_valid)
                check("cmp_signaling", {32'b0, cmp_signaling},
                      {32'b0, (in_op == FPU_CMP_FLT) || (in_op == FPU_CMP_FLE)});
            if (prev_stall) begin
                check("hold_valid", {32'b0, out_valid}, 33'd1);
                check("hold_data", out_data, prev_data);
                check("hold_exc", {28'b0, out_exc}, {28'b0, prev_exc});
            end
            if (flush) begin
                sbq.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %h, no result was pending", out_data);
                    end else begin
                        e = sbq.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_exc", {28'b0, out_exc}, {28'b0, e.exc});
                        if (chk_lat)
                            check("latency", 33'(cyc - e.cyc), 33'd2);
                        acc = e.exc;
                    end
                end
                if (in_valid && in_ready) begin
                    e.data = cur_data;
                    e.exc  = cur_exc;
                    e.cyc  = cyc;
                    sbq.push_back(e);
                    n_accept++;
                end
            end
            ff_model   = fflags_clr ? acc : (ff_model | acc);
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            prev_exc   = out_exc;
        end
    end

    task automatic send(input vec_t v, input bit clr);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        in_op      = v.op;
        in_a       = v.a;
        in_b       = v.b;
        cmp_lt     = v.lt;
        cmp_eq     = v.eq;
        cmp_exc    = v.exc;
        cur_data   = v.exp_data;
        cur_exc    = v.exp_exc;
        fflags_clr = clr;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still %b after %0d cycles, required 1", in_ready, n);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid   = 1'b0;
        fflags_clr = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk); #2;
            n++;
        end
        check("drain_pending", 33'(sbq.size()), 33'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {32'b0, out_valid}, 33'd0);
        check({tag, "_in_ready"}, {32'b0, in_ready}, 33'd1);
        check({tag, "_out_data"}, out_data, 33'd0);
        check({tag, "_out_exc"}, {28'b0, out_exc}, 33'd0);
        check({tag, "_fflags"}, {28'b0, fflags}, 33'd0);
    endtask

    initial begin
        int n0;
        vecs[0]  = '{FPU_CMP_FLT,  33'h0_8000_0000, 33'h0_8080_0000, 1'b1, 1'b0, 5'h00, 33'h1,           5'h00};
        vecs[1]  = '{FPU_CMP_FMIN, 33'h0_0000_0000, 33'h1_0000_0000, 1'b0, 1'b1, 5'h00, 33'h1_0000_0000, 5'h00};
        vecs[2]  = '{FPU_CMP_FMAX, 33'h0_0000_0000, 33'h1_0000_0000, 1'b0, 1'b1, 5'h00, 33'h0,           5'h00};
        vecs[3]  = '{FPU_CMP_FMAX, 33'h0_E000_0001, 33'h0_8000_0000, 1'b0, 1'b0, 5'h10, 33'h0_8000_0000, 5'h10};
        vecs[4]  = '{FPU_CMP_FMIN, 33'h0_E040_0000, 33'h0_E000_0001, 1'b0, 1'b0, 5'h10, 33'h0_E040_0000, 5'h10};
        vecs[5]  = '{FPU_CMP_FEQ,  33'h0_8000_0000, 33'h0_8000_0000, 1'b0, 1'b1, 5'h00, 33'h1,           5'h00};
        vecs[6]  = '{FPU_CMP_FEQ,  33'h0_8000_0000, 33'h0_8080_0000, 1'b1, 1'b0, 5'h00, 33'h0,           5'h00};
        vecs[7]  = '{FPU_CMP_FLE,  33'h0_8080_0000, 33'h0_8000_0000, 1'b0, 1'b0, 5'h00, 33'h0,           5'h00};
        vecs[8]  = '{FPU_CMP_FLE,  33'h0_8000_0000, 33'h0_8000_0000, 1'b0, 1'b1, 5'h00, 33'h1,           5'h00};
        vecs[9]  = '{3'd5,         33'h0_8000_0000, 33'h0_8000_0000, 1'b0, 1'b1, 5'h00, 33'h1,           5'h00};
        vecs[10] = '{3'd7,         33'h0_8000_0000, 33'h0_8080_0000, 1'b1, 1'b0, 5'h00, 33'h0,           5'h00};
        vecs[11] = '{FPU_CMP_FMIN, 33'h0_8000_0000, 33'h0_8080_0000, 1'b1, 1'b0, 5'h00, 33'h0_8000_0000, 5'h00};
        vecs[12] = '{FPU_CMP_FMAX, 33'h0_8000_0000, 33'h0_8080_0000, 1'b1, 1'b0, 5'h00, 33'h0_8080_0000, 5'h00};
        vecs[13] = '{FPU_CMP_FMIN, 33'h0_E040_0000, 33'h0_8080_0000, 1'b0, 1'b0, 5'h00, 33'h0_8080_0000, 5'h00};
        vecs[14] = '{FPU_CMP_FLT,  33'h0_E040_0000, 33'h0_8000_0000, 1'b0, 1'b0, 5'h10, 33'h0,           5'h10};
        vecs[15] = '{FPU_CMP_FMAX, 33'h1_8000_0000, 33'h0_8000_0000, 1'b1, 1'b0, 5'h00, 33'h0_8000_0000, 5'h00};
        vecs[16] = '{FPU_CMP_FMIN, 33'h0_8000_0000, 33'h0_E040_0000, 1'b0, 1'b0, 5'h00, 33'h0_8000_0000, 5'h00};
        vecs[17] = '{FPU_CMP_FMAX, 33'h0_8080_0000, 33'h0_8000_0000, 1'b0, 1'b0, 5'h00, 33'h0_8080_0000, 5'h00};

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streamed table at full throughput; clear on entry 6 coincides with accepting entry 4 (NV).
        chk_lat = 1'b1;
        for (int i = 0; i < NV; i++)
            send(vecs[i], i == 6);
        idle();
        drain();
        chk_lat = 1'b0;

        // Four back-to-back ops with out_ready low for three cycles.
        n0 = n_accept;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(vecs[i + 1], 1'b0);
                idle();
            end
            begin
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #2;
                check("stall_accepts", 33'(n_accept - n0), 33'd2);
                check("stall_in_ready", {32'b0, in_ready}, 33'd0);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both stages full and a new op offered.
        @(posedge clk); #1 out_ready = 1'b0;
        send(vecs[3], 1'b0);
        send(vecs[4], 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        in_op = FPU_CMP_FEQ;
        @(negedge clk); #1;
        check("flush_in_ready", {32'b0, in_ready}, 33'd1);
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("flush_out_valid", {32'b0, out_valid}, 33'd0);
        chk_lat = 1'b1;
        send(vecs[0], 1'b0);
        idle();
        drain();
        chk_lat = 1'b0;

        // Reset while both stages hold results.
        send(vecs[14], 1'b0);
        idle();
        drain();
        @(posedge clk); #1 out_ready = 1'b0;
        send(vecs[1], 1'b0);
        send(vecs[3], 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        send(vecs[12], 1'b0);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_cmp_minmax_stage.md
# fpu_cmp_minmax_stage

Registered result stage around the single-precision recoded-format comparator. It accepts FEQ/FLT/FLE/FMIN/FMAX micro-ops carrying two 33-bit recoded operands and drives the comparator's signaling select. It consumes the comparator's lt/eq/exception outputs and produces the integer compare result or the selected min/max operand through a 2-deep valid/ready pipeline. Optional sticky fflags accumulation for the FPU CSR path.

## Interface
- No parameters; widths fixed: recoded FP 33 bits, flags 5 bits (NV,DZ,OF,UF,NX; NV = bit 4).
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous kill of all in-flight ops
- in_valid / in_ready  in / out  1  upstream handshake
- in_op  in  3  0=FEQ 1=FLT 2=FLE 3=FMIN 4=FMAX; 5–7 reserved, treated as FEQ
- in_a, in_b  in  33  recoded operands
- cmp_signaling  out  1  to comparator; 1 for FLT/FLE, else 0
- cmp_lt, cmp_eq  in  1  comparator results for in_a vs in_b, same cycle
- cmp_exc  in  5  comparator flags, same cycle
- out_valid / out_ready  out / in  1  downstream handshake
- out_data  out  33  compare: {32'b0,bit}; min/max: recoded operand
- out_exc  out  5  flags of this op
- fflags  out  5  sticky accumulated flags
- fflags_clr  in  1  clear accumulator

## Operation
- Fire on in_valid & in_ready. S1 captures op, a, b, lt, eq, exc.
- S1 compute:
  - FEQ = eq.
  - FLT = lt.
  - FLE = lt | eq.
  - NaN(x) = x[31:29]==3'b111; sNaN(x) = NaN(x) & !x[22].
  - Min/max:
    - Both NaN → canonical 33'h0_E040_0000.
    - One NaN → the other operand.
    - Otherwise FMIN picks a if lt, or if eq & a[32]; else b.
    - FMAX picks a if !lt & !eq, or if eq & !a[32]; else b. This orders -0 below +0.
- out_exc = cmp_exc for every op. The comparator already flags NV on any sNaN (quiet) or any NaN (signaling).
- S2 holds the result until out_ready.
- Accumulator: fflags |= out_exc on out_valid & out_ready.
  - fflags_clr zeroes it.
  - Clear plus a same-cycle accept → fflags = out_exc of the accepted op.

## Timing
- Latency: 2 cycles, accept to out_valid. Full throughput with out_ready held high.
- S2 loads when !s2_valid | out_ready. S1 advances when S2 loads. in_ready = !s1_valid | s1 advancing. The combinational path out_ready→in_ready is intentional.
- Backpressure: the S2 value is held stable while out_valid & !out_ready. No data change while valid is pending.
- flush clears s1_valid and s2_valid next edge.
  - A same-cycle fire is dropped; in_ready is still asserted.
  - The flags of a flushed op are never accumulated.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_exc=0, fflags=0, internal valids=0.
- Reset mid-operation discards both stages immediately (asynchronous).
- cmp_signaling is combinational from in_op only.

## Configuration
- FPU_CMP_FFLAGS_ACC_EN defined: accumulator present as above.
- Not defined: fflags tied 0, fflags_clr ignored, no accumulator flops. All other behaviour identical.

## Structure
- Shared package holds:
  - op encodings (FPU_CMP_FEQ … FPU_CMP_FMAX)
  - flag bit positions
  - recoded width 33
  - canonical NaN constant 33'h0_E040_0000
- One sub-module: fpu_minmax_sel. Combinational NaN classification and min/max/compare result mux, instantiated in S1.

## Test plan
- FLT a=1.0 (33'h0_8000_0000), b=2.0 (33'h0_8080_0000), cmp_lt=1 → cmp_signaling=1; out_data=1, out_exc=0, two cycles after accept.
- FMIN a=+0 (33'h0), b=-0 (33'h1_0000_0000), cmp_eq=1 → out_data=33'h1_0000_0000. FMAX same inputs → 33'h0.
- FMAX a=sNaN 33'h0_E000_0001, b=1.0, cmp_exc=5'h10 → out_data=33'h0_8000_0000, out_exc=5'h10, fflags=5'h10. Both operands NaN → 33'h0_E040_0000.
- Back-to-back 4 ops with out_ready low 3 cycles → in_ready drops after 2 accepts, S2 held stable, all 4 results delivered in order, none lost.
- flush with in_valid=1 while both stages full → out_valid=0 next cycle, fflags unchanged, next op has latency 2.
- Reset asserted mid-stream → all outputs return to reset values immediately. With FPU_CMP_FFLAGS_ACC_EN undefined → fflags stays 0 under NV-raising traffic.
